// File: rtl/radio_seq_pkg.sv
// Shared types and default cycle constants for the radio timing sequencer.
// The Stage3 consumer uses the same defaults so both ends agree on phase lengths.
package radio_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_WAIT = 3'd1,
        RAMP     = 3'd2,
        ACTIVE   = 3'd3,
        RAMPDN   = 3'd4
    } seq_state_t;

    localparam int unsigned SETTLE_CYC_DEF = 4;
    localparam int unsigned RAMP_CYC_DEF   = 40;
    localparam int unsigned RAMPDN_CYC_DEF = 8;
    localparam int unsigned PLL_TO_CYC_DEF = 1000;
    localparam int unsigned CNT_W_DEF      = 10;

    // Radio is powered in every state except IDLE.
    function automatic logic radio_on(seq_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/radio_seq_cnt.sv
// Clearable, saturating up-counter with a terminal compare.
// tc_o is high in the cycle whose increment would reach term_i, so a caller
// that transitions on tc_o spends exactly term_i cycles in the counted phase.
module radio_seq_cnt
    import radio_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             ck_i,
    input  logic             arst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge ck_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare one bit wider so the +1 cannot overflow.
    assign tc_o = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, term_i};

endmodule

// File: rtl/radio_timing_seq.sv
// Source-end radio enable sequencer: enable -> PLL settle -> ramp -> active -> ramp-down.
// Optional PLL lock timeout is built when RADIO_SEQ_TIMEOUT_EN is defined.
// Isolated inputs (source PD off) are clamped here: start/pll forced low, stop high.
//
// state    | meaning
// IDLE     | radio off, waiting for startReq
// PLL_WAIT | radio on, counting consecutive pllSettled samples
// RAMP     | radio on, fixed ramp-up interval
// ACTIVE   | radio on, RX enable allowed
// RAMPDN   | radio on, fixed ramp-down interval, then seqDone
module radio_timing_seq
    import radio_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned RAMP_CYC   = RAMP_CYC_DEF,
    parameter int unsigned RAMPDN_CYC = RAMPDN_CYC_DEF,
    parameter int unsigned PLL_TO_CYC = PLL_TO_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic ck_i,
    input  logic arst_i,
    input  logic startReq_i,
    input  logic stopReq_i,
    input  logic rxMode_i,
    input  logic pllSettled_i,
    input  logic tArstFs_i,
    input  logic isolateIn_i,
    output logic radioEnable_o,
    output logic radioRxEn_o,
    output logic busy_o,
    output logic seqDone_o,
    output logic pllTimeout_o
);

    seq_state_t state_q, state_d;
    logic       rx_mode_q, rx_mode_d;
    logic       en_q, en_d;
    logic       rxen_q, rxen_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       to_q, to_d;

    logic             start_eff, stop_eff, pll_eff;
    logic             ph_inc, ph_clr, ph_tc;
    logic [CNT_W-1:0] ph_term;
    logic             to_hit;

    assign start_eff = startReq_i & ~isolateIn_i;
    assign stop_eff  = stopReq_i | isolateIn_i;
    assign pll_eff   = pllSettled_i & ~isolateIn_i;

    // Phase length for the current state; IDLE/ACTIVE never count.
    always_comb begin
        ph_term = CNT_W'(SETTLE_CYC);
        case (state_q)
            RAMP:    ph_term = CNT_W'(RAMP_CYC);
            RAMPDN:  ph_term = CNT_W'(RAMPDN_CYC);
            default: ph_term = CNT_W'(SETTLE_CYC);
        endcase
    end

    // Any cycle that does not advance the phase restarts it from zero.
    assign ph_clr = ~ph_inc;

    radio_seq_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .ck_i   (ck_i),
        .arst_i (arst_i),
        .clr_i  (ph_clr),
        .inc_i  (ph_inc),
        .term_i (ph_term),
        .tc_o   (ph_tc)
    );

`ifdef RADIO_SEQ_TIMEOUT_EN
    logic to_clr, to_inc;

    // Total time spent in PLL_WAIT this session; survives pllSettled glitches
    // and bounces back from RAMP, cleared only while idle.
    assign to_clr = (state_q == IDLE);
    assign to_inc = (state_q == PLL_WAIT);

    radio_seq_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .ck_i   (ck_i),
        .arst_i (arst_i),
        .clr_i  (to_clr),
        .inc_i  (to_inc),
        .term_i (CNT_W'(PLL_TO_CYC)),
        .tc_o   (to_hit)
    );
`else
    assign to_hit = 1'b0;
`endif

    // Next state, counter control and next registered outputs; force-stop dominates.
    always_comb begin
        state_d   = state_q;
        rx_mode_d = rx_mode_q;
        done_d    = 1'b0;
        to_d      = 1'b0;
        ph_inc    = 1'b0;
        if (tArstFs_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_eff) begin
                        state_d   = PLL_WAIT;
                        rx_mode_d = rxMode_i;
                    end
                end
                PLL_WAIT: begin
                    if (stop_eff) begin
                        state_d = RAMPDN;
                    end else if (to_hit) begin
                        state_d = RAMPDN;
                        to_d    = 1'b1;
                    end else if (pll_eff) begin
                        if (ph_tc) state_d = RAMP;
                        else       ph_inc  = 1'b1;
                    end
                end
                RAMP: begin
                    if (stop_eff) begin
                        state_d = RAMPDN;
                    end else if (!pll_eff) begin
                        state_d = PLL_WAIT;
                    end else if (ph_tc) begin
                        state_d = ACTIVE;
                    end else begin
                        ph_inc = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (stop_eff || !pll_eff) state_d = RAMPDN;
                end
                RAMPDN: begin
                    if (ph_tc) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ph_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        en_d   = radio_on(state_d);
        busy_d = (state_d != IDLE);
        rxen_d = (state_d == ACTIVE) && rx_mode_d;
    end

    // State and output registers update together so outputs track the new state.
    always_ff @(posedge ck_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            rx_mode_q <= 1'b0;
            en_q      <= 1'b0;
            rxen_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_mode_q <= rx_mode_d;
            en_q      <= en_d;
            rxen_q    <= rxen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            to_q      <= to_d;
        end
    end

    assign radioEnable_o = en_q;
    assign radioRxEn_o   = rxen_q;
    assign busy_o        = busy_q;
    assign seqDone_o     = done_q;
    assign pllTimeout_o  = to_q;

endmodule

// File: tb/tb_radio_timing_seq.sv
// Scoreboard bench for radio_timing_seq: stimulus pushes the expected output
// vector for each upcoming edge, a monitor pops and compares after the edge.
module tb_radio_timing_seq;

    localparam int SETTLE = 4;
    localparam int RAMPC  = 40;
    localparam int DNC    = 8;
`ifdef RADIO_SEQ_TIMEOUT_EN
    localparam int TOC      = 20;
    localparam int TO_PARAM = 20;
`else
    localparam int TOC      = 0;
    localparam int TO_PARAM = 1000;
`endif

    logic ck = 1'b0;
    logic arst = 1'b0;
    logic st = 1'b0, sp = 1'b0, rx = 1'b0, pll = 1'b0, fs = 1'b0, iso = 1'b0;
    logic en_o, rxen_o, busy_o, done_o, to_o;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];

    // Behavioural model: phase index plus run/elapsed/total counts.
    int ph  = 0;   // 0 idle, 1 wait lock, 2 ramp, 3 active, 4 ramp down
    int run = 0;   // consecutive settled samples
    int el  = 0;   // cycles elapsed in ramp / ramp down
    int tot = 0;   // total lock-wait cycles this session
    bit mrx = 1'b0;

    always #5 ck = ~ck;

    radio_timing_seq #(.PLL_TO_CYC(TO_PARAM)) dut (
        .ck_i          (ck),
        .arst_i        (arst),
        .startReq_i    (st),
        .stopReq_i     (sp),
        .rxMode_i      (rx),
        .pllSettled_i  (pll),
        .tArstFs_i     (fs),
        .isolateIn_i   (iso),
        .radioEnable_o (en_o),
        .radioRxEn_o   (rxen_o),
        .busy_o        (busy_o),
        .seqDone_o     (done_o),
        .pllTimeout_o  (to_o)
    );

    task automatic model_step();
        bit s, p, l, d, t;
        logic [4:0] e;
        s = st && !iso;
        p = sp || iso;
        l = pll && !iso;
        d = 1'b0;
        t = 1'b0;
        if (fs) begin
            ph = 0;
        end else begin
            case (ph)
                0: if (s) begin ph = 1; mrx = rx; run = 0; tot = 0; end
                1: begin
                    tot++;
                    if (p) begin ph = 4; el = 0; end
                    else if (TOC > 0 && tot >= TOC) begin ph = 4; el = 0; t = 1'b1; end
                    else if (l) begin
                        run++;
                        if (run == SETTLE) begin ph = 2; el = 0; end
                    end else run = 0;
                end
                2: begin
                    if (p) begin ph = 4; el = 0; end
                    else if (!l) begin ph = 1; run = 0; end
                    else begin
                        el++;
                        if (el == RAMPC) ph = 3;
                    end
                end
                3: if (p || !l) begin ph = 4; el = 0; end
                default: begin
                    el++;
                    if (el == DNC) begin ph = 0; d = 1'b1; end
                end
            endcase
        end
        e = {ph != 0, (ph == 3) && mrx, ph != 0, d, t};
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic s, input logic p, input logic r,
                         input logic l, input logic f, input logic i);
        @(negedge ck);
        st = s; sp = p; rx = r; pll = l; fs = f; iso = i;
        model_step();
    endtask

    task automatic hold(input int n, input logic l);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 1'b0, l, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        logic [4:0] g;
        @(negedge ck);
        st = 0; sp = 0; rx = 0; pll = 0; fs = 0; iso = 0;
        #1 arst = 1'b1;
        #1;
        g = {en_o, rxen_o, busy_o, done_o, to_o};
        checks++;
        if (g !== 5'b0) begin
            errors++;
            $display("FAIL async_reset t=%0t got=%b exp=00000", $time, g);
        end
        ph = 0; run = 0; el = 0; tot = 0; mrx = 1'b0;
        exp_q.delete();
        #1 arst = 1'b0;
        model_step();
    endtask

    // Monitor: compare DUT outputs one step after each active edge.
    always @(posedge ck) begin
        logic [4:0] e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {en_o, rxen_o, busy_o, done_o, to_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%b exp=%b (en rxen busy done to)", $time, g, e);
            end
        end
    end

    initial begin
        do_reset();

        // Nominal RX session: start c0, settled from c1, stop at c60.
        apply(1, 0, 1, 0, 0, 0);
        hold(59, 1'b1);
        apply(0, 1, 0, 1, 0, 0);
        hold(12, 1'b1);

        // Async reset in the middle of ACTIVE.
        apply(1, 0, 1, 0, 0, 0);
        hold(50, 1'b1);
        do_reset();

        // Lock glitch during settle, then a drop during ramp.
        apply(1, 0, 0, 0, 0, 0);
        hold(3, 1'b1);
        hold(1, 1'b0);
        hold(14, 1'b1);
        hold(1, 1'b0);
        hold(10, 1'b1);
        apply(0, 1, 0, 1, 0, 0);
        hold(12, 1'b1);

        // Force-stop in RAMP together with stop.
        apply(1, 0, 1, 0, 0, 0);
        hold(10, 1'b1);
        apply(0, 1, 0, 1, 1, 0);
        hold(12, 1'b1);

        // Start and stop together while idle.
        apply(1, 1, 1, 1, 0, 0);
        hold(12, 1'b1);

        // Isolation during ACTIVE, start attempts while isolated.
        apply(1, 0, 1, 0, 0, 0);
        hold(50, 1'b1);
        for (int k = 0; k < 12; k++) apply(1, 0, 1, 1, 0, 1);
        hold(3, 1'b1);

        // Lock never arrives: timeout build ramps down, default build keeps waiting.
        apply(1, 0, 1, 0, 0, 0);
        hold(40, 1'b0);
        apply(0, 1, 0, 0, 0, 0);
        hold(12, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ((n % 700) == 699) begin
                do_reset();
            end else begin
                apply(($urandom % 4) == 0, ($urandom % 64) == 0, $urandom % 2,
                      ($urandom % 32) != 0, ($urandom % 200) == 0, ($urandom % 150) == 0);
            end
        end

        @(negedge ck);
        @(negedge ck);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
